// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl -- issue control for the multiply/divide unit.
//
// Holds the E-stage MD operation register, starts the MD unit, and predicts
// how long the unit stays busy so that a following MD instruction in D can be
// stalled without waiting for md_busy.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req             exception/interrupt flush, kills the E-stage op
//   id_valid/id_op  D-stage instruction valid and MD op
//   id_rs/id_rt     D-stage forwarded operands
//   md_busy         busy from the MD unit
//   stall_d         hold D and insert a bubble into E
//   md_start        start pulse to the MD unit
//   md_op/md_a/md_b E-stage op and operands to the MD unit
//   err_mismatch    sticky predicted-busy vs md_busy disagreement
//
// Build option: define MD_ISSUE_CHECK_EN to build the mismatch checker;
// otherwise err_mismatch is tied low.
module md_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        id_valid,
  input  logic [3:0]  id_op,
  input  logic [31:0] id_rs,
  input  logic [31:0] id_rt,
  input  logic        md_busy,
  output logic        stall_d,
  output logic        md_start,
  output logic [3:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        err_mismatch
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } pstate_e;

  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;

  pstate_e     state;
  logic [3:0]  pcnt;
  logic        pbusy;
  logic        e_is_mul;
  logic        e_is_div;
  logic        id_is_md;

  always_comb begin
    e_is_mul = (e_op == OP_MULT) || (e_op == OP_MULTU);
    e_is_div = (e_op == OP_DIV)  || (e_op == OP_DIVU);
    id_is_md = (id_op >= OP_MULT) && (id_op <= OP_MFLO);
    pbusy    = (state != S_IDLE);
    md_start = e_valid & (e_is_mul | e_is_div) & ~req;
    // Encodings above MFLO are treated as NOP on the way out.
    md_op    = (e_valid && !req && (e_op <= OP_MFLO)) ? e_op : OP_NOP;
    md_a     = e_a;
    md_b     = e_b;
    stall_d  = id_valid & id_is_md & (md_start | pbusy | md_busy);
  end

  // E-stage register: a stall or a flush both load a bubble.
  always_ff @(posedge clk) begin
    if (reset || req || stall_d) begin
      e_valid <= 1'b0;
      e_op    <= OP_NOP;
      e_a     <= '0;
      e_b     <= '0;
    end else begin
      e_valid <= id_valid;
      e_op    <= id_op;
      e_a     <= id_rs;
      e_b     <= id_rt;
    end
  end

  // Busy predictor: counts the MD latency, frozen while a flush is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md_start && e_is_mul) begin
            state <= S_MUL;
            pcnt  <= 4'd5;
          end else if (md_start && e_is_div) begin
            state <= S_DIV;
            pcnt  <= 4'd10;
          end
        end
        default: begin
          if (!req) begin
            if (pcnt == 4'd1) begin
              state <= S_IDLE;
              pcnt  <= '0;
            end else begin
              pcnt <= pcnt - 4'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef MD_ISSUE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_mismatch <= 1'b0;
    end else if (md_busy != pbusy) begin
      err_mismatch <= 1'b1;
    end
  end
`else
  always_comb err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl -- scoreboard bench for md_issue_ctrl.
// The driver runs a cycle-level reference model (E stage as a record, busy
// time as a remaining-cycle count) and pushes the expected MD-unit output;
// a separate monitor pops and compares whenever an output is expected or the
// DUT presents one. Build option MD_ISSUE_CHECK_EN is honoured by the model.
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset, req, id_valid, md_busy;
  logic [3:0]  id_op;
  logic [31:0] id_rs, id_rt;
  logic        stall_d, md_start, err_mismatch;
  logic [3:0]  md_op;
  logic [31:0] md_a, md_b;

  md_issue_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .id_valid(id_valid), .id_op(id_op),
    .id_rs(id_rs), .id_rt(id_rt), .md_busy(md_busy), .stall_d(stall_d),
    .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .err_mismatch(err_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } instr_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
  } exp_t;

  instr_t iq[$];
  exp_t   sbq[$];
  instr_t m_e;
  int     p_left;
  int     md_left;
  logic   m_err;
  int     nvec = 0;
  int     nerr = 0;
  int     stall_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i.v = 1'b1; i.op = op; i.a = a; i.b = b;
    return i;
  endfunction

  // One clock cycle: drive, predict, check stall/err, then advance the model.
  task automatic step(input logic r, input logic rst, input logic spur, input logic kill);
    instr_t d;
    exp_t   e;
    logic   pb, busy_in, exp_start, exp_stall;
    logic [3:0] exp_op;
    @(negedge clk);
    d = (iq.size() > 0) ? iq[0] : instr_t'('0);
    busy_in  = ((md_left > 0) || spur) && !kill;
    id_valid = d.v; id_op = d.op; id_rs = d.a; id_rt = d.b;
    req = r; reset = rst; md_busy = busy_in;
    pb        = (p_left > 0);
    exp_start = m_e.v && (m_e.op inside {[1:4]}) && !r;
    exp_op    = (m_e.v && !r && m_e.op <= 4'd8) ? m_e.op : 4'd0;
    exp_stall = d.v && (d.op inside {[1:8]}) && (exp_start || pb || busy_in);
    if (exp_op != 4'd0 || exp_start) begin
      e.op = exp_op; e.a = m_e.a; e.b = m_e.b; e.start = exp_start;
      sbq.push_back(e);
    end
    #1;
    chk("stall_d", {31'd0, stall_d}, {31'd0, exp_stall});
    chk("err_mismatch", {31'd0, err_mismatch}, {31'd0, m_err});
    stall_cnt += int'(stall_d);
    @(posedge clk);
    if (rst) begin
      m_e = '0; p_left = 0; md_left = 0; m_err = 1'b0;
    end else begin
`ifdef MD_ISSUE_CHECK_EN
      if (busy_in != pb) m_err = 1'b1;
`endif
      if (p_left > 0) begin
        if (!r) p_left--;
      end else if (exp_start) begin
        p_left = (m_e.op <= 4'd2) ? 5 : 10;
      end
      if (md_left > 0) begin
        if (!r) md_left--;
      end else if (exp_start) begin
        md_left = (m_e.op <= 4'd2) ? 5 : 10;
      end
      m_e = (r || exp_stall) ? instr_t'('0) : d;
    end
    if (!exp_stall && iq.size() > 0) void'(iq.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares the E-stage output against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0 || md_start || md_op != 4'd0) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", {28'd0, md_op}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("md_op", {28'd0, md_op}, {28'd0, e.op});
          chk("md_start", {31'd0, md_start}, {31'd0, e.start});
          chk("md_a", md_a, e.a);
          chk("md_b", md_b, e.b);
        end
      end
    end
  end

  initial begin
    m_e = '0; p_left = 0; md_left = 0; m_err = 1'b0; stall_cnt = 0;
    reset = 1'b1; req = 1'b0; id_valid = 1'b0; id_op = '0;
    id_rs = '0; id_rt = '0; md_busy = 1'b0;

    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_md_start", {31'd0, md_start}, 32'd0);
    chk("rst_md_op", {28'd0, md_op}, 32'd0);
    chk("rst_err", {31'd0, err_mismatch}, 32'd0);

    // MULT then MFLO: start cycle plus 5 busy cycles of stall.
    iq.push_back(mk(4'd1, 32'd6, 32'd7));
    iq.push_back(mk(4'd8, 32'd0, 32'd0));
    stall_cnt = 0;
    idle(10);
    chk("mult_stall_cycles", 32'(stall_cnt), 32'd6);

    // DIVU 100/7 then MFHI: start cycle plus 10 busy cycles.
    iq.push_back(mk(4'd4, 32'd100, 32'd7));
    iq.push_back(mk(4'd7, 32'd0, 32'd0));
    stall_cnt = 0;
    idle(15);
    chk("divu_stall_cycles", 32'(stall_cnt), 32'd11);

    // MULT killed by req while in E: no start, no prediction.
    iq.push_back(mk(4'd1, 32'hdead, 32'hbeef));
    iq.push_back(mk(4'd8, 32'd0, 32'd0));
    stall_cnt = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("killed_mult_stalls", 32'(stall_cnt), 32'd0);

    // DIV with req held 3 cycles at pcnt=6: busy stretches to 13 cycles.
    iq.push_back(mk(4'd3, 32'd1000, 32'd3));
    iq.push_back(mk(4'd7, 32'd0, 32'd0));
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) step((i >= 6 && i <= 8), 1'b0, 1'b0, 1'b0);
    chk("div_freeze_stalls", 32'(stall_cnt), 32'd14);

    // Reset at pcnt=3 of DIV aborts the prediction.
    iq.push_back(mk(4'd3, 32'd50, 32'd5));
    iq.push_back(mk(4'd8, 32'd0, 32'd0));
    stall_cnt = 0;
    for (int i = 0; i < 14; i++) step(1'b0, (i == 9), 1'b0, 1'b0);
    chk("div_reset_stalls", 32'(stall_cnt), 32'd9);

    // md_busy dropped during a MUL prediction.
    iq.push_back(mk(4'd2, 32'd3, 32'd4));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, (i == 3));
    #1;
`ifdef MD_ISSUE_CHECK_EN
    chk("err_sticky", {31'd0, err_mismatch}, 32'd1);
`else
    chk("err_tied_low", {31'd0, err_mismatch}, 32'd0);
`endif
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("err_after_reset", {31'd0, err_mismatch}, 32'd0);

    // Randomized traffic: mixed ops, flushes, resets and spurious busy.
    for (int i = 0; i < 3000; i++) begin
      if (iq.size() < 2) begin
        instr_t n;
        n.v  = ($urandom_range(0, 3) != 0);
        n.op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 8));
        n.a  = $urandom;
        n.b  = $urandom;
        iq.push_back(n);
      end
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0),
           ($urandom_range(0, 19) == 0), 1'b0);
    end
    iq.delete();
    idle(4);

    @(negedge clk);
    #3;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
